// File: rtl/letter_pool_if.sv
// Bundle of frame, generator, keypress, renderer and status signals for letter_pool.
// Strobes: frame_tick and key_valid are single-cycle pulses with no back-pressure; a strobe the pool cannot take is dropped.
interface letter_pool_if #(parameter int SLOTS = 8);
  localparam int IDX_W = $clog2(SLOTS);

  logic             frame_tick;
  logic [7:0]       gen_ch;
  logic [2:0]       gen_speed;
  logic [8:0]       gen_x;
  logic [9:0]       gen_y;
  logic             key_valid;
  logic [7:0]       key_ch;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_active;
  logic [7:0]       rd_ch;
  logic [8:0]       rd_x;
  logic [9:0]       rd_y;
  logic             hit;
  logic             miss;
  logic             busy;
  logic [15:0]      score;
  logic [7:0]       miss_cnt;
  logic [4:0]       active_cnt;

  modport master (
    output frame_tick, gen_ch, gen_speed, gen_x, gen_y, key_valid, key_ch, rd_idx,
    input  rd_active, rd_ch, rd_x, rd_y, hit, miss, busy, score, miss_cnt, active_cnt
  );

  modport slave (
    input  frame_tick, gen_ch, gen_speed, gen_x, gen_y, key_valid, key_ch, rd_idx,
    output rd_active, rd_ch, rd_x, rd_y, hit, miss, busy, score, miss_cnt, active_cnt
  );
endinterface

// File: rtl/letter_pool.sv
// Pool of falling letters: per-frame move scan, periodic spawn, keypress hits, miss/score counters.
// Optional macro LETTER_POOL_DUP_CHECK_EN rejects spawns whose letter is already on screen.
module letter_pool #(
  parameter int         SLOTS        = 8,
  parameter int         SPAWN_FRAMES = 30,
  parameter logic [8:0] BOTTOM_X     = 9'd440
) (
  input  logic         clk,
  input  logic         rst_n,
  letter_pool_if.slave bus,
  output logic [1:0]   dbg_state
);
  localparam int IDX_W = $clog2(SLOTS);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MOVE = 2'd1, ST_SPAWN = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       spawn_cnt_q, spawn_cnt_d;
  logic             pend_q, pend_d;
  logic [7:0]       pend_ch_q, pend_ch_d;
  logic [15:0]      score_q, score_d;
  logic [7:0]       miss_cnt_q, miss_cnt_d;
  logic [4:0]       active_cnt_q, active_cnt_d;
  logic             hit_q, hit_d, miss_q, miss_d;

  logic       active_q [SLOTS];
  logic       active_d [SLOTS];
  logic [7:0] ch_q     [SLOTS];
  logic [7:0] ch_d     [SLOTS];
  logic [2:0] speed_q  [SLOTS];
  logic [2:0] speed_d  [SLOTS];
  logic [8:0] x_q      [SLOTS];
  logic [8:0] x_d      [SLOTS];
  logic [9:0] y_q      [SLOTS];
  logic [9:0] y_d      [SLOTS];

  logic       key_go, key_found, free_found, dup;
  logic [7:0] key_val;
  logic [9:0] step;
  logic [4:0] sum;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    spawn_cnt_d = spawn_cnt_q;
    pend_d      = pend_q;
    pend_ch_d   = pend_ch_q;
    score_d     = score_q;
    miss_cnt_d  = miss_cnt_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    active_d    = active_q;
    ch_d        = ch_q;
    speed_d     = speed_q;
    x_d         = x_q;
    y_d         = y_q;
    key_go      = 1'b0;
    key_val     = 8'd0;
    key_found   = 1'b0;
    free_found  = 1'b0;
    dup         = 1'b0;
    step        = 10'd0;
    sum         = 5'd0;

    // A key arriving while the scan/spawn runs is held until IDLE; a second one is dropped.
    if (state_q != ST_IDLE && !pend_q && bus.key_valid) begin
      pend_d    = 1'b1;
      pend_ch_d = bus.key_ch;
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          key_go  = 1'b1;
          key_val = pend_ch_q;
          pend_d  = 1'b0;
        end else if (bus.key_valid) begin
          key_go  = 1'b1;
          key_val = bus.key_ch;
        end
        if (key_go) begin
          for (int i = 0; i < SLOTS; i++) begin
            if (!key_found && active_q[i] && ch_q[i] == key_val) begin
              key_found   = 1'b1;
              active_d[i] = 1'b0;
            end
          end
        end
        if (key_found) begin
          hit_d = 1'b1;
          if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
        end
        if (bus.frame_tick) begin
          state_d = ST_MOVE;
          idx_d   = '0;
        end
      end
      ST_MOVE: begin
        if (active_q[idx_q]) begin
          step = {1'b0, x_q[idx_q]} + {7'd0, speed_q[idx_q]};
          if (step >= {1'b0, BOTTOM_X}) begin
            active_d[idx_q] = 1'b0;
            miss_d          = 1'b1;
            if (miss_cnt_q != 8'hFF) miss_cnt_d = miss_cnt_q + 8'd1;
          end else begin
            x_d[idx_q] = step[8:0];
          end
        end
        if (idx_q == IDX_W'(SLOTS - 1)) state_d = ST_SPAWN;
        else                            idx_d   = idx_q + 1'b1;
      end
      ST_SPAWN: begin
        state_d = ST_IDLE;
        if (spawn_cnt_q == 8'(SPAWN_FRAMES - 1)) begin
          spawn_cnt_d = 8'd0;
`ifdef LETTER_POOL_DUP_CHECK_EN
          for (int i = 0; i < SLOTS; i++) begin
            if (active_q[i] && ch_q[i] == bus.gen_ch) dup = 1'b1;
          end
`endif
          if (!dup) begin
            for (int i = 0; i < SLOTS; i++) begin
              if (!free_found && !active_q[i]) begin
                free_found  = 1'b1;
                active_d[i] = 1'b1;
                ch_d[i]     = bus.gen_ch;
                speed_d[i]  = bus.gen_speed;
                x_d[i]      = bus.gen_x;
                y_d[i]      = bus.gen_y;
              end
            end
          end
        end else begin
          spawn_cnt_d = spawn_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    for (int i = 0; i < SLOTS; i++) sum = sum + {4'd0, active_d[i]};
    active_cnt_d = sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      spawn_cnt_q  <= 8'd0;
      pend_q       <= 1'b0;
      pend_ch_q    <= 8'd0;
      score_q      <= 16'd0;
      miss_cnt_q   <= 8'd0;
      active_cnt_q <= 5'd0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        active_q[i] <= 1'b0;
        ch_q[i]     <= 8'd0;
        speed_q[i]  <= 3'd0;
        x_q[i]      <= 9'd0;
        y_q[i]      <= 10'd0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      spawn_cnt_q  <= spawn_cnt_d;
      pend_q       <= pend_d;
      pend_ch_q    <= pend_ch_d;
      score_q      <= score_d;
      miss_cnt_q   <= miss_cnt_d;
      active_cnt_q <= active_cnt_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      active_q     <= active_d;
      ch_q         <= ch_d;
      speed_q      <= speed_d;
      x_q          <= x_d;
      y_q          <= y_d;
    end
  end

  always_comb begin
    bus.rd_active = 1'b0;
    bus.rd_ch     = 8'd0;
    bus.rd_x      = 9'd0;
    bus.rd_y      = 10'd0;
    if (int'(bus.rd_idx) < SLOTS) begin
      bus.rd_active = active_q[bus.rd_idx];
      bus.rd_ch     = ch_q[bus.rd_idx];
      bus.rd_x      = x_q[bus.rd_idx];
      bus.rd_y      = y_q[bus.rd_idx];
    end
  end

  assign bus.hit        = hit_q;
  assign bus.miss       = miss_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.score      = score_q;
  assign bus.miss_cnt   = miss_cnt_q;
  assign bus.active_cnt = active_cnt_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_letter_pool.sv
// Directed bench for letter_pool (SLOTS=8, SPAWN_FRAMES=1, BOTTOM_X=440).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_letter_pool;
  localparam int SLOTS = 8;
  localparam int IDX_W = $clog2(SLOTS);

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;
  int         miss_seen;
  int         hit_seen;

  letter_pool_if #(.SLOTS(SLOTS)) bus ();

  letter_pool #(.SLOTS(SLOTS), .SPAWN_FRAMES(1), .BOTTOM_X(9'd440)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_pulses();
    miss_seen += int'(bus.miss);
    hit_seen  += int'(bus.hit);
  endtask

  task automatic chk_slot(input int i, input logic act, input logic [7:0] ch, input logic [8:0] x);
    logic [31:0] iv;
    iv = 32'(i);
    bus.rd_idx = iv[IDX_W-1:0];
    #1;
    chk($sformatf("slot%0d_active", i), 32'(bus.rd_active), 32'(act));
    if (act) begin
      chk($sformatf("slot%0d_ch", i), 32'(bus.rd_ch), 32'(ch));
      chk($sformatf("slot%0d_x", i), 32'(bus.rd_x), 32'(x));
    end
  endtask

  task automatic set_gen(input logic [7:0] ch, input logic [2:0] sp, input logic [8:0] x, input logic [9:0] y);
    bus.gen_ch    = ch;
    bus.gen_speed = sp;
    bus.gen_x     = x;
    bus.gen_y     = y;
  endtask

  task automatic frame(input logic [7:0] ch, input logic [2:0] sp, input logic [8:0] x);
    set_gen(ch, sp, x, 10'd0);
    miss_seen = 0;
    hit_seen  = 0;
    bus.frame_tick = 1'b1;
    tick();
    bus.frame_tick = 1'b0;
    count_pulses();
    repeat (SLOTS + 1) begin
      tick();
      count_pulses();
    end
  endtask

  task automatic press(input logic [7:0] ch);
    bus.key_valid = 1'b1;
    bus.key_ch    = ch;
    tick();
    bus.key_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.frame_tick = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key_ch     = 8'd0;
    bus.rd_idx     = '0;
    set_gen(8'd0, 3'd0, 9'd0, 10'd0);
    repeat (3) tick();

    // Reset state
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_score", 32'(bus.score), 32'd0);
    chk("rst_miss_cnt", 32'(bus.miss_cnt), 32'd0);
    chk("rst_active_cnt", 32'(bus.active_cnt), 32'd0);
    chk("rst_hit", 32'(bus.hit), 32'd0);
    chk("rst_miss", 32'(bus.miss), 32'd0);
    chk_slot(0, 1'b0, 8'd0, 9'd0);
    rst_n = 1'b1;
    tick();

    // First spawn, with latency and busy window checked cycle-exactly
    set_gen(8'h41, 3'd2, 9'd0, 10'd10);
    bus.frame_tick = 1'b1;
    tick();
    bus.frame_tick = 1'b0;
    chk("lat_busy_move", 32'(bus.busy), 32'd1);
    chk("lat_state_move", 32'(dbg_state), 32'd1);
    repeat (SLOTS) tick();
    chk("lat_state_spawn", 32'(dbg_state), 32'd2);
    chk("lat_active_pre", 32'(bus.active_cnt), 32'd0);
    tick();
    chk("lat_busy_idle", 32'(bus.busy), 32'd0);
    chk("spawn_active_cnt", 32'(bus.active_cnt), 32'd1);
    chk_slot(0, 1'b1, 8'h41, 9'd0);
    chk("spawn_y", 32'(bus.rd_y), 32'd10);

    // Movement and a letter placed just above the bottom
    frame(8'h42, 3'd2, 9'd438);
    chk_slot(0, 1'b1, 8'h41, 9'd2);
    chk_slot(1, 1'b1, 8'h42, 9'd438);
    chk("mv_active_cnt", 32'(bus.active_cnt), 32'd2);
    chk("mv_no_miss", 32'(miss_seen), 32'd0);

    // 438+2 reaches 440: miss, slot freed and reused by the spawn
    frame(8'h4B, 3'd1, 9'd0);
    chk("miss_pulses", 32'(miss_seen), 32'd1);
    chk("miss_cnt1", 32'(bus.miss_cnt), 32'd1);
    chk_slot(0, 1'b1, 8'h41, 9'd4);
    chk_slot(1, 1'b1, 8'h4B, 9'd0);
    chk("miss_active_cnt", 32'(bus.active_cnt), 32'd2);

    // Two 'K' letters, in slots 1 and 3
    frame(8'h51, 3'd1, 9'd0);
    frame(8'h4B, 3'd1, 9'd100);
    chk_slot(3, 1'b1, 8'h4B, 9'd100);
    chk("k_active_cnt", 32'(bus.active_cnt), 32'd4);

    // Key 'K' in IDLE frees only the lowest-index match
    press(8'h4B);
    chk("hit_pulse", 32'(bus.hit), 32'd1);
    chk("hit_score1", 32'(bus.score), 32'd1);
    chk("hit_active_cnt", 32'(bus.active_cnt), 32'd3);
    chk_slot(1, 1'b0, 8'd0, 9'd0);
    chk_slot(3, 1'b1, 8'h4B, 9'd100);
    tick();
    chk("hit_one_cycle", 32'(bus.hit), 32'd0);

    // 'K' then 'Z' during MOVE: 'K' held, 'Z' dropped (a 'Z' is spawned to prove it)
    set_gen(8'h5A, 3'd1, 9'd0, 10'd0);
    bus.frame_tick = 1'b1;
    tick();
    bus.frame_tick = 1'b0;
    bus.key_valid = 1'b1;
    bus.key_ch    = 8'h4B;
    tick();
    bus.key_ch    = 8'h5A;
    tick();
    bus.key_valid = 1'b0;
    repeat (SLOTS - 1) tick();
    chk("pend_idle", 32'(bus.busy), 32'd0);
    chk("pend_hit_pre", 32'(bus.hit), 32'd0);
    tick();
    chk("pend_hit", 32'(bus.hit), 32'd1);
    chk("pend_score2", 32'(bus.score), 32'd2);
    chk_slot(3, 1'b0, 8'd0, 9'd0);
    chk_slot(1, 1'b1, 8'h5A, 9'd0);
    tick();
    chk("pend_z_dropped", 32'(bus.score), 32'd2);
    chk("pend_active_cnt", 32'(bus.active_cnt), 32'd3);

    // Key coincident with frame_tick: key handled, then the scan starts
    set_gen(8'h43, 3'd1, 9'd0, 10'd0);
    bus.frame_tick = 1'b1;
    bus.key_valid  = 1'b1;
    bus.key_ch     = 8'h51;
    tick();
    bus.frame_tick = 1'b0;
    bus.key_valid  = 1'b0;
    chk("co_busy", 32'(bus.busy), 32'd1);
    chk("co_hit", 32'(bus.hit), 32'd1);
    chk("co_score3", 32'(bus.score), 32'd3);
    chk("co_active_cnt", 32'(bus.active_cnt), 32'd2);
    repeat (SLOTS + 1) tick();
    chk_slot(2, 1'b1, 8'h43, 9'd0);
    chk_slot(0, 1'b1, 8'h41, 9'd12);
    chk("co_active_after", 32'(bus.active_cnt), 32'd3);

    // Fill the pool, then a spawn with nowhere to go
    for (int i = 0; i < 5; i++) frame(8'h44 + 8'(i), 3'd1, 9'd0);
    chk("full_active_cnt", 32'(bus.active_cnt), 32'd8);
    chk_slot(7, 1'b1, 8'h48, 9'd0);
    frame(8'h58, 3'd1, 9'd0);
    chk("full_discard_cnt", 32'(bus.active_cnt), 32'd8);
    chk_slot(7, 1'b1, 8'h48, 9'd1);
    chk("full_miss_cnt", 32'(bus.miss_cnt), 32'd1);

    // Free slot 0, then spawn a letter already on screen
    press(8'h41);
    chk("a_score4", 32'(bus.score), 32'd4);
    chk("a_active_cnt", 32'(bus.active_cnt), 32'd7);
    tick();
    frame(8'h5A, 3'd1, 9'd0);
`ifdef LETTER_POOL_DUP_CHECK_EN
    chk("dup_active_cnt", 32'(bus.active_cnt), 32'd7);
    chk_slot(0, 1'b0, 8'd0, 9'd0);
`else
    chk("dup_active_cnt", 32'(bus.active_cnt), 32'd8);
    chk_slot(0, 1'b1, 8'h5A, 9'd0);
`endif

    // Reset in the middle of the scan, at slot 4
    bus.frame_tick = 1'b1;
    tick();
    bus.frame_tick = 1'b0;
    repeat (4) tick();
    chk("mid_state_move", 32'(dbg_state), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(bus.busy), 32'd0);
    chk("mid_active_cnt", 32'(bus.active_cnt), 32'd0);
    chk("mid_score", 32'(bus.score), 32'd0);
    chk("mid_miss_cnt", 32'(bus.miss_cnt), 32'd0);
    chk("mid_hit", 32'(bus.hit), 32'd0);
    chk("mid_miss", 32'(bus.miss), 32'd0);
    chk_slot(5, 1'b0, 8'd0, 9'd0);
    miss_seen = 0;
    hit_seen  = 0;
    repeat (3) begin
      tick();
      count_pulses();
    end
    rst_n = 1'b1;
    repeat (SLOTS + 2) begin
      tick();
      count_pulses();
    end
    chk("post_rst_no_miss", 32'(miss_seen), 32'd0);
    chk("post_rst_idle", 32'(bus.busy), 32'd0);
    frame(8'h52, 3'd1, 9'd7);
    chk_slot(0, 1'b1, 8'h52, 9'd7);
    chk_slot(1, 1'b0, 8'd0, 9'd0);
    chk("post_rst_active_cnt", 32'(bus.active_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
